qc_ldpc_encoder: RTL

QC_LDPC_ENCODER -- requirements
Module: qc_ldpc_encoder

---
 rtl/qc_ldpc_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/qc_ldpc_encoder.sv
// QC-LDPC encoder: accumulates rotated info blocks per layer, then streams the
// dual-diagonal parity blocks (p_0 = s_0, p_r = s_r ^ p_(r-1)).
module qc_ldpc_encoder #(
    parameter int Z  = 88,
    parameter int KB = 24,
    parameter int MB = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Z-1:0]          in_data,
    output logic [$clog2(MB)-1:0] shift_row,
    output logic [$clog2(KB)-1:0] shift_col,
    input  logic [6:0]            shift_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Z-1:0]          out_data,
    output logic                  busy,
    output logic                  done
);
    localparam int RW = $clog2(MB);
    localparam int CW = $clog2(KB);
    localparam logic [RW-1:0] ROW_LAST = RW'(MB - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(KB - 1);

    typedef enum logic [1:0] {IDLE, WAIT_INFO, ACCUM, OUTPUT} state_t;

    state_t               state_q, state_d;
    logic [MB-1:0][Z-1:0] acc_q, acc_d;
    logic [Z-1:0]         prev_q, prev_d;
    logic [Z-1:0]         info_q, info_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 done_q, done_d;

    logic [2*Z-1:0]       rot_wide;
    logic [Z-1:0]         rot;
    logic                 shift_live;
    logic [Z-1:0]         parity;

    // Doubling the block turns the cyclic rotation into a plain right shift.
    assign rot_wide   = {info_q, info_q} >> shift_value;
    assign rot        = rot_wide[Z-1:0];
    assign shift_live = int'(shift_value) < Z;
    assign parity     = acc_q[row_q] ^ ((row_q == '0) ? '0 : prev_q);

    assign in_ready  = (state_q == WAIT_INFO);
    assign out_valid = (state_q == OUTPUT);
    assign out_data  = (state_q == OUTPUT) ? parity : '0;
    assign shift_row = (state_q == ACCUM) ? row_q : '0;
    assign shift_col = (state_q == ACCUM) ? col_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        prev_d  = prev_q;
        info_d  = info_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    prev_d  = '0;
                    col_d   = '0;
                    state_d = WAIT_INFO;
                end
            end
            WAIT_INFO: begin
                if (in_valid) begin
                    info_d  = in_data;
                    row_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (shift_live) begin
                    acc_d[row_q] = acc_q[row_q] ^ rot;
                end
                if (row_q == ROW_LAST) begin
                    if (col_q == COL_LAST) begin
                        row_d   = '0;
                        state_d = OUTPUT;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = WAIT_INFO;
                    end
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    prev_d = parity;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            prev_q  <= '0;
            info_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prev_q  <= prev_d;
            info_q  <= info_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end
endmodule
